vram_port_arbiter: RTL and testbench
====================================

# vram_port_arbiter

Shares one single-port, 32-bit synchronous VRAM (600 text words plus the control word) between the Avalon-MM host port and the VGA text renderer's glyph-code fetch port. The display fetch has priority so scan-out never misses a word. The host port is stalled with AVL_WAITREQUEST until it is served. A starvation counter bounds the host stall. The block sits between the Avalon fabric, the renderer and the VRAM macro inside the VGA text IP.

## Interface
- NUM_WORDS, 601: implemented words; the control word is at index NUM_WORDS-1.
- STARVE_LIMIT, 8: consecutive lost cycles after which the host wins once.
- CLK  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-high reset
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave controls
- AVL_BYTE_EN  in  4  write byte enables
- AVL_ADDR  in  10  word address
- AVL_WRITEDATA  in  32  write data
- AVL_READDATA  out  32  read data, valid when a read completes
- AVL_WAITREQUEST  out  1  host stall
- DISP_REQ  in  1  renderer fetch request, held until granted
- DISP_ADDR  in  10  renderer word address
- DISP_GNT  out  1  fetch accepted this cycle
- DISP_VALID  out  1  DISP_DATA valid this cycle
- DISP_DATA  out  32  fetched word
- RAM_ADDR  out  10, RAM_WE  out  1, RAM_BE  out  4, RAM_WDATA  out  32  VRAM port
- RAM_RDATA  in  32  VRAM read data, one cycle after the address

## Operation
- Host pending (HP) = AVL_CS & (AVL_READ | AVL_WRITE) & host FSM in H_IDLE. AVL_READ takes precedence if AVL_READ and AVL_WRITE are both high.
- One VRAM access per cycle. Arbitration is combinational:
  - If DISP_REQ and not starve, the display is granted.
  - Otherwise, if HP, the host is granted.
  - Otherwise, no access: RAM_ADDR=0, RAM_WE=0, RAM_BE=0.
- Display grant:
  - DISP_GNT=1, RAM_ADDR=DISP_ADDR, RAM_WE=0, RAM_BE=4'hF.
  - A return flag is registered, so DISP_VALID=1 and DISP_DATA=RAM_RDATA on the next cycle.
- Host write grant:
  - RAM_WE=1, RAM_BE=AVL_BYTE_EN, RAM_WDATA=AVL_WRITEDATA.
  - AVL_WAITREQUEST=0 the same cycle, completing the write.
  - Any byte-enable pattern passes through, including 4'b0000, which completes with no bytes changed.
- Host read grant: state moves H_IDLE→H_RD_RET.
  - In H_RD_RET, AVL_WAITREQUEST=0 and AVL_READDATA=RAM_RDATA. State returns to H_IDLE on the next edge.
  - The RAM port is free for a display grant during H_RD_RET.
  - The host cannot issue a new access in H_RD_RET.
- AVL_WAITREQUEST=1 whenever the host is pending and not completing; it is 0 when the host is idle.
- AVL_READDATA=0 when no read is completing.
- Out-of-range addresses (≥ NUM_WORDS):
  - Host writes are dropped (RAM_WE=0) but still complete.
  - Host reads and display reads complete normally and return 0.
- Starve counter, 4 bits:
  - Increments each cycle HP is high and the display is granted.
  - Clears on a host grant or when HP is low.
  - starve = (count ≥ STARVE_LIMIT).

## Timing
- Reset (asynchronous) forces:
  - State H_IDLE, counter 0, return flags 0.
  - DISP_VALID=0, DISP_DATA=0, AVL_READDATA=0, RAM_WE=0.
  - AVL_WAITREQUEST=1 while RESET is high.
- Display latency: grant at cycle t, data at t+1. Back-to-back grants each cycle give DISP_VALID every cycle.
- Host write: 0 wait cycles if uncontested; each display-won cycle adds one.
- Host read: minimum 1 wait cycle (grant at t, complete at t+1).
- Simultaneous host and display requests with counter < limit: the display wins and the host counter increments.
- Reset asserted in H_RD_RET: the read is abandoned, and the host must reissue it after reset.

## Configuration
- VRAM_ARB_STARVE_EN defined: the starve counter and host-priority override exist as described.
- VRAM_ARB_STARVE_EN undefined: strict display priority, and the host waits for as long as DISP_REQ stays high. The counter logic is omitted.

## Test plan
- Reset release, then host write addr 5, data 32'hDEADBEEF, BE 4'hF, no display traffic → RAM_WE pulse at addr 5 and AVL_WAITREQUEST=0 the same cycle.
- Host read addr 5 with the RAM model holding 32'hDEADBEEF → AVL_WAITREQUEST=1 for 1 cycle, then 0 with AVL_READDATA=32'hDEADBEEF.
- DISP_REQ and a host write arrive together, with DISP_REQ held continuously:
  - With VRAM_ARB_STARVE_EN: the host is granted on cycle 9 (STARVE_LIMIT=8), and DISP_GNT=0 on that cycle only.
  - Without VRAM_ARB_STARVE_EN: the host is never granted while DISP_REQ is high.
- Host write to addr 700 → completes with RAM_WE=0. Display read of addr 650 → DISP_VALID with DISP_DATA=0.
- Host read granted, then a display request during H_RD_RET → both complete, and DISP_VALID arrives one cycle after the host completion.
- RESET asserted mid-read in H_RD_RET → outputs take their reset values immediately, and a fresh read after release returns the correct data.

Source files
------------

// File: rtl/vram_port_arbiter.sv
// Arbitrates one single-port VRAM between the Avalon host and the display glyph fetch (display first).
// Define VRAM_ARB_STARVE_EN to bound host stall with a starvation counter; otherwise strict display priority.
module vram_port_arbiter #(
  parameter int NUM_WORDS    = 601,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [3:0]  AVL_BYTE_EN,
  input  logic [9:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  output logic        AVL_WAITREQUEST,
  input  logic        DISP_REQ,
  input  logic [9:0]  DISP_ADDR,
  output logic        DISP_GNT,
  output logic        DISP_VALID,
  output logic [31:0] DISP_DATA,
  output logic [9:0]  RAM_ADDR,
  output logic        RAM_WE,
  output logic [3:0]  RAM_BE,
  output logic [31:0] RAM_WDATA,
  input  logic [31:0] RAM_RDATA
);
  typedef enum logic {H_IDLE, H_RD_RET} host_state_t;

  localparam logic [10:0] NUM_WORDS_W = NUM_WORDS[10:0];

  host_state_t state_reg;
  logic        host_oor_reg;
  logic        disp_ret_reg;
  logic        disp_oor_reg;

  logic host_pending;
  logic host_addr_ok;
  logic disp_addr_ok;
  logic starve;
  logic disp_win;
  logic host_win;

  // Read wins over write when the host raises both.
  assign host_pending = AVL_CS & (AVL_READ | AVL_WRITE) & (state_reg == H_IDLE);
  assign host_addr_ok = ({1'b0, AVL_ADDR} < NUM_WORDS_W);
  assign disp_addr_ok = ({1'b0, DISP_ADDR} < NUM_WORDS_W);

`ifdef VRAM_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIMIT_W = STARVE_LIMIT[3:0];
  logic [3:0] starve_cnt_reg;

  assign starve = (starve_cnt_reg >= STARVE_LIMIT_W);

  // Counts consecutive cycles the waiting host lost to the display; cannot pass the limit
  // because the host wins the cycle after it is reached.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt_reg <= '0;
    end else if (host_pending && disp_win) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end else begin
      starve_cnt_reg <= '0;
    end
  end
`else
  assign starve = 1'b0;
`endif

  assign disp_win = ~RESET & DISP_REQ & ~starve;
  assign host_win = ~RESET & ~disp_win & host_pending;

  always_comb begin
    RAM_ADDR  = '0;
    RAM_WE    = 1'b0;
    RAM_BE    = '0;
    RAM_WDATA = '0;
    if (disp_win) begin
      RAM_ADDR = DISP_ADDR;
      RAM_BE   = 4'hF;
    end else if (host_win) begin
      RAM_ADDR = AVL_ADDR;
      if (AVL_READ) begin
        RAM_BE = 4'hF;
      end else begin
        RAM_WE    = host_addr_ok;
        RAM_BE    = AVL_BYTE_EN;
        RAM_WDATA = AVL_WRITEDATA;
      end
    end
  end

  assign DISP_GNT   = disp_win;
  assign DISP_VALID = disp_ret_reg;
  assign DISP_DATA  = (disp_ret_reg && !disp_oor_reg) ? RAM_RDATA : 32'd0;

  assign AVL_READDATA = (state_reg == H_RD_RET && !host_oor_reg) ? RAM_RDATA : 32'd0;

  always_comb begin
    if (RESET) begin
      AVL_WAITREQUEST = 1'b1;
    end else if (state_reg == H_RD_RET) begin
      AVL_WAITREQUEST = 1'b0;
    end else begin
      AVL_WAITREQUEST = host_pending & ~(host_win & ~AVL_READ);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= H_IDLE;
      host_oor_reg <= 1'b0;
      disp_ret_reg <= 1'b0;
      disp_oor_reg <= 1'b0;
    end else begin
      disp_ret_reg <= disp_win;
      disp_oor_reg <= ~disp_addr_ok;
      case (state_reg)
        H_IDLE: begin
          if (host_win && AVL_READ) begin
            state_reg    <= H_RD_RET;
            host_oor_reg <= ~host_addr_ok;
          end
        end
        H_RD_RET: state_reg <= H_IDLE;
        default:  state_reg <= H_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: VRAM macro model, behavioural reference, directed and random traffic.
// Honours VRAM_ARB_STARVE_EN the same way the design does.
module tb_vram_port_arbiter;
  localparam int NW  = 601;
  localparam int LIM = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
  logic [3:0]  AVL_BYTE_EN = '0;
  logic [9:0]  AVL_ADDR = '0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic [31:0] AVL_READDATA;
  logic        AVL_WAITREQUEST;
  logic        DISP_REQ = 1'b0;
  logic [9:0]  DISP_ADDR = '0;
  logic        DISP_GNT, DISP_VALID;
  logic [31:0] DISP_DATA;
  logic [9:0]  RAM_ADDR;
  logic        RAM_WE;
  logic [3:0]  RAM_BE;
  logic [31:0] RAM_WDATA;
  logic [31:0] RAM_RDATA;

  int checks = 0;
  int errors = 0;

  vram_port_arbiter #(.NUM_WORDS(NW), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
    .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_GNT(DISP_GNT),
    .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
    .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_BE(RAM_BE), .RAM_WDATA(RAM_WDATA),
    .RAM_RDATA(RAM_RDATA)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // VRAM macro: 1024 physical words, read data one cycle after the address.
  logic [31:0] ram [0:1023];
  always @(posedge CLK) begin
    if (RAM_WE) ram[RAM_ADDR] <= merge(ram[RAM_ADDR], RAM_WDATA, RAM_BE);
    RAM_RDATA <= ram[RAM_ADDR];
  end

  // Reference model: architectural memory contents plus what each port is owed next cycle.
  logic [31:0] ref_mem [0:NW-1];
  logic        m_rd_ret, m_disp_ret;
  logic [31:0] m_rd_data, m_disp_data;
  int          m_lost;

  function automatic logic host_wants();
    return AVL_CS && (AVL_READ || AVL_WRITE) && !m_rd_ret;
  endfunction

  // Returns {display wins, host wins} for the current inputs.
  function automatic logic [1:0] decide();
    logic st;
`ifdef VRAM_ARB_STARVE_EN
    st = (m_lost >= LIM);
`else
    st = 1'b0;
`endif
    return {DISP_REQ && !st, host_wants() && !(DISP_REQ && !st)};
  endfunction

  logic [1:0] u_d;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_rd_ret    <= 1'b0;
      m_disp_ret  <= 1'b0;
      m_rd_data   <= '0;
      m_disp_data <= '0;
      m_lost      <= 0;
    end else begin
      u_d = decide();
      m_rd_ret    <= u_d[0] && AVL_READ;
      m_rd_data   <= (int'(AVL_ADDR) < NW) ? ref_mem[AVL_ADDR] : 32'd0;
      m_disp_ret  <= u_d[1];
      m_disp_data <= (int'(DISP_ADDR) < NW) ? ref_mem[DISP_ADDR] : 32'd0;
      if (u_d[0] && !AVL_READ && int'(AVL_ADDR) < NW)
        ref_mem[AVL_ADDR] <= merge(ref_mem[AVL_ADDR], AVL_WRITEDATA, AVL_BYTE_EN);
      m_lost <= (host_wants() && u_d[1]) ? m_lost + 1 : 0;
    end
  end

  logic [1:0] c_d;
  logic       c_wr;
  always @(negedge CLK) begin
    if (RESET) begin
      chk("rst_wait", 32'(AVL_WAITREQUEST), 32'd1);
      chk("rst_we", 32'(RAM_WE), 32'd0);
      chk("rst_gnt", 32'(DISP_GNT), 32'd0);
      chk("rst_dvalid", 32'(DISP_VALID), 32'd0);
      chk("rst_ddata", DISP_DATA, 32'd0);
      chk("rst_rdata", AVL_READDATA, 32'd0);
    end else begin
      c_d  = decide();
      c_wr = !AVL_READ;
      chk("gnt", 32'(DISP_GNT), 32'(c_d[1]));
      chk("ram_addr", 32'(RAM_ADDR), c_d[1] ? 32'(DISP_ADDR) : c_d[0] ? 32'(AVL_ADDR) : 32'd0);
      chk("ram_we", 32'(RAM_WE), 32'(c_d[0] && c_wr && int'(AVL_ADDR) < NW));
      if (c_d[1]) chk("ram_be_disp", 32'(RAM_BE), 32'hF);
      else if (c_d[0] && c_wr) begin
        chk("ram_be_wr", 32'(RAM_BE), 32'(AVL_BYTE_EN));
        chk("ram_wdata", RAM_WDATA, AVL_WRITEDATA);
      end else if (!c_d[0]) chk("ram_be_idle", 32'(RAM_BE), 32'd0);
      chk("wait", 32'(AVL_WAITREQUEST), m_rd_ret ? 32'd0 : 32'(host_wants() && !(c_d[0] && c_wr)));
      chk("rdata", AVL_READDATA, m_rd_ret ? m_rd_data : 32'd0);
      chk("dvalid", 32'(DISP_VALID), 32'(m_disp_ret));
      chk("ddata", DISP_DATA, m_disp_ret ? m_disp_data : 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic host_idle();
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic host_op(input logic rd, input logic wr, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
  endtask

  logic h_done, d_done;
  int   r;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    for (int i = 0; i < NW; i++) ref_mem[i] = ram[i];
    repeat (3) @(negedge CLK);
    chk("lit_rst_wait", 32'(AVL_WAITREQUEST), 32'd1);
    tick();
    RESET = 1'b0;

    // Uncontested write: completes the same cycle.
    host_op(1'b0, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
    @(negedge CLK);
    chk("lit_wr_we", 32'(RAM_WE), 32'd1);
    chk("lit_wr_addr", 32'(RAM_ADDR), 32'd5);
    chk("lit_wr_wait", 32'(AVL_WAITREQUEST), 32'd0);
    tick();
    host_idle();

    // Read: one wait cycle then data.
    host_op(1'b1, 1'b0, 10'd5, 32'd0, 4'h0);
    @(negedge CLK);
    chk("lit_rd_wait1", 32'(AVL_WAITREQUEST), 32'd1);
    tick();
    @(negedge CLK);
    chk("lit_rd_wait2", 32'(AVL_WAITREQUEST), 32'd0);
    chk("lit_rd_data", AVL_READDATA, 32'hDEADBEEF);
    tick();
    host_idle();

    // Display held against a pending host write.
    DISP_REQ = 1'b1; DISP_ADDR = 10'd10;
    host_op(1'b0, 1'b1, 10'd6, 32'h12345678, 4'h3);
`ifdef VRAM_ARB_STARVE_EN
    for (int c = 1; c <= 9; c++) begin
      @(negedge CLK);
      chk("lit_starve_gnt", 32'(DISP_GNT), 32'(c < 9));
      chk("lit_starve_wait", 32'(AVL_WAITREQUEST), 32'(c < 9));
      tick();
    end
    host_idle();
    DISP_REQ = 1'b0;
`else
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      chk("lit_strict_gnt", 32'(DISP_GNT), 32'd1);
      chk("lit_strict_wait", 32'(AVL_WAITREQUEST), 32'd1);
      chk("lit_strict_we", 32'(RAM_WE), 32'd0);
      tick();
    end
    DISP_REQ = 1'b0;
    @(negedge CLK);
    chk("lit_strict_done", 32'(RAM_WE), 32'd1);
    tick();
    host_idle();
`endif

    // Out-of-range accesses.
    host_op(1'b0, 1'b1, 10'd700, 32'hFFFFFFFF, 4'hF);
    @(negedge CLK);
    chk("lit_oor_we", 32'(RAM_WE), 32'd0);
    chk("lit_oor_wait", 32'(AVL_WAITREQUEST), 32'd0);
    tick();
    host_idle();
    DISP_REQ = 1'b1; DISP_ADDR = 10'd650;
    tick();
    DISP_REQ = 1'b0;
    @(negedge CLK);
    chk("lit_oor_dvalid", 32'(DISP_VALID), 32'd1);
    chk("lit_oor_ddata", DISP_DATA, 32'd0);
    tick();

    // Display slips in during the read-return cycle.
    host_op(1'b1, 1'b0, 10'd5, 32'd0, 4'h0);
    tick();
    DISP_REQ = 1'b1; DISP_ADDR = 10'd5;
    @(negedge CLK);
    chk("lit_rr_gnt", 32'(DISP_GNT), 32'd1);
    chk("lit_rr_wait", 32'(AVL_WAITREQUEST), 32'd0);
    chk("lit_rr_data", AVL_READDATA, 32'hDEADBEEF);
    tick();
    host_idle();
    DISP_REQ = 1'b0;
    @(negedge CLK);
    chk("lit_rr_dvalid", 32'(DISP_VALID), 32'd1);
    chk("lit_rr_ddata", DISP_DATA, 32'hDEADBEEF);
    tick();

    // Reset during read return, then reissue.
    host_op(1'b1, 1'b0, 10'd5, 32'd0, 4'h0);
    tick();
    #3 RESET = 1'b1;
    #1;
    chk("lit_mr_wait", 32'(AVL_WAITREQUEST), 32'd1);
    chk("lit_mr_rdata", AVL_READDATA, 32'd0);
    host_idle();
    tick();
    tick();
    RESET = 1'b0;
    host_op(1'b1, 1'b0, 10'd5, 32'd0, 4'h0);
    @(negedge CLK);
    chk("lit_mr2_wait1", 32'(AVL_WAITREQUEST), 32'd1);
    tick();
    @(negedge CLK);
    chk("lit_mr2_data", AVL_READDATA, 32'hDEADBEEF);
    tick();
    host_idle();

    // Random traffic; both masters hold a request until it is accepted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      h_done = AVL_CS && (AVL_READ || AVL_WRITE) && !AVL_WAITREQUEST;
      d_done = DISP_REQ && DISP_GNT;
      tick();
      if (!AVL_CS || h_done) begin
        if ($urandom_range(0, 9) < 6) begin
          r = $urandom_range(0, 9);
          host_op(r < 4 || r == 9, r >= 4,
                  ($urandom_range(0, 9) < 7) ? 10'($urandom_range(0, 31)) :
                  ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, NW - 1)) : 10'($urandom_range(NW, 1023)),
                  $urandom, 4'($urandom_range(0, 15)));
        end else host_idle();
      end
      if (!DISP_REQ || d_done) begin
        DISP_REQ  = ($urandom_range(0, 1) == 1);
        DISP_ADDR = ($urandom_range(0, 9) < 8) ? 10'($urandom_range(0, 31)) : 10'($urandom_range(0, 1023));
      end
    end

    host_idle();
    DISP_REQ = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
